sdram_cmd_sched: RTL and testbench
==================================

// Module: sdram_cmd_sched
// PURPOSE
//  Parametrised SDRAM command issuer: accepts one abstract command per valid/ready
//  handshake, drives registered SDRAM pins (sadd, ba, cs_n, ras_n, cas_n, we_n, cke).
//  Enforces inter-command timing (tRCD/tRP/tRFC/tMRD) with an internal wait counter.
//  Sits between the controller FSM and the SDRAM pad ring; supports N chip selects.
// PARAMETERS
//  N_CS   2   number of chip selects (cs_n width)
//  CS_W   1   width of cmd_cs index, >= clog2(N_CS)
//  ADD_W  12  SDRAM address bus width (>= 11)
//  BA_W   2   bank address width
//  ROW_W  12  row field width, <= ADD_W
//  COL_W  9   column field width, <= 10
//  T_RCD  2   ACT -> RD/WR spacing, cycles (>= 1)
//  T_RP   2   PRE/PREA -> next command spacing, cycles (>= 1)
//  T_RFC  7   REF -> next command spacing, cycles (>= 1)
//  T_MRD  2   LMR -> next command spacing, cycles (>= 1)
//  T_RAS  5   ACT -> PRE/PREA minimum, cycles (used only with CMDGEN_TRAS_EN)
// PORTS
//  clk0       in   1      clock, all logic on rising edge
//  reset      in   1      asynchronous, active-high
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      issuer can accept (combinational)
//  cmd_op     in   3      0 BST,1 ACT,2 RD,3 WR,4 PRE,5 PREA,6 REF,7 LMR
//  cmd_cs     in   CS_W   target chip index
//  cmd_ba     in   BA_W   target bank
//  cmd_row    in   ROW_W  row (ACT) or mode word (LMR)
//  cmd_col    in   COL_W  column (RD/WR)
//  cmd_ap     in   1      auto-precharge for RD/WR (drives A10)
//  sadd       out  ADD_W  SDRAM address
//  ba         out  BA_W   bank address
//  cs_n       out  N_CS   chip selects, active low
//  ras_n/cas_n/we_n out 1 command strobes, active low
//  cke        out  1      clock enable
// BEHAVIOUR
//  Reset: sadd=0, ba=0, cs_n=all 1, ras_n=cas_n=we_n=1, cke=0, wait counter=0,
//   tRAS counter=0; reset mid-operation aborts immediately, no command completes.
//  cke=1 from first clk0 edge after reset release, held thereafter.
//  Handshake: accept on edge where cmd_valid & cmd_ready; requester holds fields
//   stable while cmd_valid & !cmd_ready. cmd_ready = (wait_cnt==0) [& tRAS gate].
//  Latency: accepted command appears on pins immediately after the accepting edge
//   (1 register stage); in any cycle with no acceptance pins show NOP with all
//   cs_n=1 (deselect); sadd/ba hold last value.
//  Pin encoding (ras_n,cas_n,we_n): ACT 011, RD 101, WR 100, PRE/PREA 010,
//   REF 001, LMR 000, BST 110.
//  cs_n: REF, PREA, LMR drive all N_CS low; others drive only bit cmd_cs low.
//   cmd_cs >= N_CS: no bit asserted (command silently dropped on pins, still accepted).
//  sadd: ACT -> row zero-extended; RD/WR -> col zero-extended, A10=cmd_ap;
//   PRE -> A10=0; PREA -> A10=1, rest 0; LMR -> cmd_row, ba=0; BST/REF -> unchanged.
//  ba: cmd_ba for ACT/RD/WR/PRE; 0 for LMR; unchanged otherwise.
//  Wait counter loaded on accept with T-1: ACT T_RCD-1, PRE/PREA T_RP-1,
//   REF T_RFC-1, LMR T_MRD-1, RD/WR/BST 0; decrements to 0 and saturates.
//   Hence T=1 allows back-to-back; spacing between pin commands = T cycles.
//  No bank/row state tracking; legality beyond timing is the requester's job.
// CONFIGURATION
//  CMDGEN_TRAS_EN defined: extra counter loaded T_RAS-1 on ACT, decrements to 0;
//   cmd_ready deasserted for PRE/PREA (only) while it is nonzero.
//  Undefined: no tRAS counter; PRE/PREA gated only by wait counter.
// TESTING
//  Reset held, then released -> all outputs at reset values; cke=1 one edge later.
//  ACT cs=1 ba=2 row=0x3A5, then RD col=0x1F ap=1 -> ACT pins 011, cs_n=2'b01,
//   sadd=0x3A5; cmd_ready low 1 cycle; RD 2 cycles later, sadd=0x41F, pins 101.
//  REF with valid held -> cs_n=00, pins 001; next cmd waits exactly 7 cycles.
//  PREA then LMR row=0x032 -> sadd=0x400/010, then 0x032 ba=0 000 two cycles later.
//  Reset asserted while wait counter=5 -> outputs reset at once, cmd_ready=1 after.
//  CMDGEN_TRAS_EN: ACT then PRE -> PRE issued 5 cycles after ACT; RD unaffected.

Source files
------------

// File: rtl/sdram_cmd_sched.sv
// SDRAM command issuer: one abstract command per handshake to registered pins, with inter-command spacing.
// Optional macro CMDGEN_TRAS_EN adds an ACT->PRE/PREA minimum (T_RAS) gate.
module sdram_cmd_sched #(
   parameter int N_CS  = 2,
   parameter int CS_W  = 1,
   parameter int ADD_W = 12,
   parameter int BA_W  = 2,
   parameter int ROW_W = 12,
   parameter int COL_W = 9,
   parameter int T_RCD = 2,
   parameter int T_RP  = 2,
   parameter int T_RFC = 7,
   parameter int T_MRD = 2,
   parameter int T_RAS = 5
) (
   input  logic             clk0,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CS_W-1:0]  cmd_cs,
   input  logic [BA_W-1:0]  cmd_ba,
   input  logic [ROW_W-1:0] cmd_row,
   input  logic [COL_W-1:0] cmd_col,
   input  logic             cmd_ap,
   output logic [ADD_W-1:0] sadd,
   output logic [BA_W-1:0]  ba,
   output logic [N_CS-1:0]  cs_n,
   output logic             ras_n,
   output logic             cas_n,
   output logic             we_n,
   output logic             cke
);

   typedef enum logic [2:0] {
      OP_BST, OP_ACT, OP_RD, OP_WR, OP_PRE, OP_PREA, OP_REF, OP_LMR
   } op_e;

   // Counters hold T-1, so $clog2 of the largest spacing is wide enough.
   localparam int T_M1  = (T_RCD > T_RP)  ? T_RCD : T_RP;
   localparam int T_M2  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
   localparam int T_M3  = (T_M1 > T_M2)   ? T_M1  : T_M2;
   localparam int T_MAX = (T_M3 > T_RAS)  ? T_M3  : T_RAS;
   localparam int WC_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   op_e              op;
   logic             accept;
   logic [WC_W-1:0]  wait_cnt, nxt_wait;
   logic [ADD_W-1:0] nxt_sadd, row_ext, col_ext;
   logic [BA_W-1:0]  nxt_ba;
   logic [N_CS-1:0]  nxt_cs, cs_one;
   logic [2:0]       nxt_pins;

   assign op     = op_e'(cmd_op);
   assign accept = cmd_valid & cmd_ready;

`ifdef CMDGEN_TRAS_EN
   logic [WC_W-1:0] tras_cnt, nxt_tras;

   always_comb begin
      cmd_ready = (wait_cnt == '0) &&
                  !(((op == OP_PRE) || (op == OP_PREA)) && (tras_cnt != '0));
      nxt_tras  = (tras_cnt != '0) ? tras_cnt - 1'b1 : '0;
      if (accept && (op == OP_ACT)) nxt_tras = WC_W'(T_RAS - 1);
   end

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) tras_cnt <= '0;
      else       tras_cnt <= nxt_tras;
   end
`else
   assign cmd_ready = (wait_cnt == '0);
`endif

   always_comb begin
      for (int i = 0; i < N_CS; i++) cs_one[i] = (cmd_cs != CS_W'(i));
      row_ext = '0;
      row_ext[ROW_W-1:0] = cmd_row;
      col_ext = '0;
      col_ext[COL_W-1:0] = cmd_col;
      col_ext[10] = cmd_ap;

      nxt_sadd = sadd;
      nxt_ba   = ba;
      nxt_cs   = '1;
      nxt_pins = 3'b111;
      nxt_wait = (wait_cnt != '0) ? wait_cnt - 1'b1 : '0;

      if (accept) begin
         case (op)
            OP_BST: begin
               nxt_pins = 3'b110;
               nxt_cs   = cs_one;
               nxt_wait = '0;
            end
            OP_ACT: begin
               nxt_pins = 3'b011;
               nxt_cs   = cs_one;
               nxt_sadd = row_ext;
               nxt_ba   = cmd_ba;
               nxt_wait = WC_W'(T_RCD - 1);
            end
            OP_RD, OP_WR: begin
               nxt_pins = (op == OP_RD) ? 3'b101 : 3'b100;
               nxt_cs   = cs_one;
               nxt_sadd = col_ext;
               nxt_ba   = cmd_ba;
               nxt_wait = '0;
            end
            OP_PRE: begin
               nxt_pins     = 3'b010;
               nxt_cs       = cs_one;
               nxt_sadd[10] = 1'b0;
               nxt_ba       = cmd_ba;
               nxt_wait     = WC_W'(T_RP - 1);
            end
            OP_PREA: begin
               nxt_pins     = 3'b010;
               nxt_cs       = '0;
               nxt_sadd     = '0;
               nxt_sadd[10] = 1'b1;
               nxt_wait     = WC_W'(T_RP - 1);
            end
            OP_REF: begin
               nxt_pins = 3'b001;
               nxt_cs   = '0;
               nxt_wait = WC_W'(T_RFC - 1);
            end
            OP_LMR: begin
               nxt_pins = 3'b000;
               nxt_cs   = '0;
               nxt_sadd = row_ext;
               nxt_ba   = '0;
               nxt_wait = WC_W'(T_MRD - 1);
            end
            default: nxt_pins = 3'b111;
         endcase
      end
   end

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         sadd     <= '0;
         ba       <= '0;
         cs_n     <= '1;
         ras_n    <= 1'b1;
         cas_n    <= 1'b1;
         we_n     <= 1'b1;
         cke      <= 1'b0;
         wait_cnt <= '0;
      end else begin
         sadd     <= nxt_sadd;
         ba       <= nxt_ba;
         cs_n     <= nxt_cs;
         {ras_n, cas_n, we_n} <= nxt_pins;
         cke      <= 1'b1;
         wait_cnt <= nxt_wait;
      end
   end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Bench for sdram_cmd_sched: directed commands feed a scoreboard queue; a monitor
// checks pin encoding and spacing from the previous pin command.
module tb_sdram_cmd_sched;

   logic        clk0 = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [0:0]  cmd_cs = '0;
   logic [1:0]  cmd_ba = '0;
   logic [11:0] cmd_row = '0;
   logic [8:0]  cmd_col = '0;
   logic        cmd_ap = 1'b0;
   logic [11:0] sadd;
   logic [1:0]  ba;
   logic [1:0]  cs_n;
   logic        ras_n, cas_n, we_n, cke;

   typedef struct {
      logic [1:0]  cs_n;
      logic [2:0]  pins;
      logic [11:0] sadd;
      logic [1:0]  ba;
      int          gap;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last = 0;

   localparam logic [2:0] BST = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                          PRE = 3'd4, PREA = 3'd5, REF = 3'd6, LMR = 3'd7;
`ifdef CMDGEN_TRAS_EN
   localparam int ACT_PRE_GAP = 5;
`else
   localparam int ACT_PRE_GAP = 2;
`endif

   sdram_cmd_sched dut (
      .clk0(clk0), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cs(cmd_cs), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .cmd_ap(cmd_ap), .sadd(sadd), .ba(ba), .cs_n(cs_n),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .cke(cke)
   );

   always #5 clk0 = ~clk0;
   always @(posedge clk0) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic cs, input logic [1:0] b,
                        input logic [11:0] row, input logic [8:0] col, input logic ap,
                        input logic [1:0] ecs, input logic [2:0] ep,
                        input logic [11:0] es, input logic [1:0] eb, input int eg);
      bit done = 1'b0;
      @(negedge clk0);
      cmd_op = op; cmd_cs = cs; cmd_ba = b; cmd_row = row; cmd_col = col; cmd_ap = ap;
      cmd_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         if (cmd_ready) begin
            q.push_back('{ecs, ep, es, eb, eg});
            @(posedge clk0);
            done = 1'b1;
         end else begin
            @(negedge clk0);
         end
      end
      #1 cmd_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: op %0d never accepted", op);
      end
   endtask

   // Monitor: every non-deselect cycle on the pins must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk0);
         if (!reset && cs_n != 2'b11) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: cs_n %b pins %b%b%b", cs_n, ras_n, cas_n, we_n);
            end else begin
               e = q.pop_front();
               check("pins", {13'd0, cs_n, ras_n, cas_n, we_n, sadd, ba},
                     {13'd0, e.cs_n, e.pins, e.sadd, e.ba});
               if (e.gap != 0) check("gap", cyc - last, e.gap);
            end
            last = cyc;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk0);
      @(negedge clk0);
      check("reset_state", {cke, cs_n, ras_n, cas_n, we_n, sadd, ba},
            {1'b0, 2'b11, 3'b111, 12'h000, 2'b00});
      reset = 1'b0;
      #1 check("cke_before_edge", cke, 1'b0);
      @(posedge clk0);
      #1 check("cke_after_edge", {cke, cmd_ready}, 2'b11);

      issue(ACT, 1'b1, 2'd2, 12'h3A5, 9'h000, 1'b0, 2'b01, 3'b011, 12'h3A5, 2'd2, 0);
      check("ready_low_after_act", cmd_ready, 1'b0);
      @(posedge clk0);
      #1 check("ready_back_after_act", cmd_ready, 1'b1);
      issue(RD,  1'b1, 2'd2, 12'h000, 9'h01F, 1'b1, 2'b01, 3'b101, 12'h41F, 2'd2, 2);
      issue(WR,  1'b0, 2'd1, 12'h000, 9'h1AB, 1'b1, 2'b10, 3'b100, 12'h5AB, 2'd1, 1);
      issue(BST, 1'b0, 2'd3, 12'h000, 9'h000, 1'b0, 2'b10, 3'b110, 12'h5AB, 2'd1, 1);
      issue(PRE, 1'b0, 2'd3, 12'h000, 9'h000, 1'b0, 2'b10, 3'b010, 12'h1AB, 2'd3, 1);
      issue(REF, 1'b0, 2'd0, 12'h000, 9'h000, 1'b0, 2'b00, 3'b001, 12'h1AB, 2'd3, 2);
      issue(ACT, 1'b0, 2'd0, 12'hFFF, 9'h000, 1'b0, 2'b10, 3'b011, 12'hFFF, 2'd0, 7);
      issue(PRE, 1'b1, 2'd1, 12'h000, 9'h000, 1'b0, 2'b01, 3'b010, 12'hBFF, 2'd1, ACT_PRE_GAP);
      issue(PREA,1'b0, 2'd2, 12'h000, 9'h000, 1'b0, 2'b00, 3'b010, 12'h400, 2'd1, 2);
      issue(LMR, 1'b0, 2'd3, 12'h032, 9'h000, 1'b0, 2'b00, 3'b000, 12'h032, 2'd0, 2);
      issue(ACT, 1'b1, 2'd3, 12'h123, 9'h000, 1'b0, 2'b01, 3'b011, 12'h123, 2'd3, 2);
      issue(RD,  1'b1, 2'd3, 12'h000, 9'h000, 1'b0, 2'b01, 3'b101, 12'h000, 2'd3, 2);
      issue(REF, 1'b1, 2'd0, 12'h000, 9'h000, 1'b0, 2'b00, 3'b001, 12'h000, 2'd3, 1);

      // REF loaded the wait counter with 6; one edge later it holds 5.
      @(posedge clk0);
      #1 reset = 1'b1;
      #1 check("mid_reset", {cke, cmd_ready, cs_n, ras_n, cas_n, we_n, sadd, ba},
               {1'b0, 1'b1, 2'b11, 3'b111, 12'h000, 2'b00});
      repeat (2) @(posedge clk0);
      @(negedge clk0);
      reset = 1'b0;
      #1 check("ready_after_reset", cmd_ready, 1'b1);
      issue(ACT, 1'b0, 2'd1, 12'h055, 9'h000, 1'b0, 2'b10, 3'b011, 12'h055, 2'd1, 0);
      check("ready_low_after_reset_act", cmd_ready, 1'b0);

      repeat (4) @(posedge clk0);
      #1 check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
